// File: rtl/vedic_dot_sequencer_if.sv
// Operand stream, multiplier drive/return and result stream of the dot-product sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding system's view.
interface vedic_dot_sequencer_if #(
  parameter int ACC_W = 24
);
  logic [15:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_p;
  logic [ACC_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             err;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, mul_p, m_axis_tready,
    output s_axis_tready, mul_a, mul_b, m_axis_tdata, m_axis_tvalid, err
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, mul_p, m_axis_tready,
    input  s_axis_tready, mul_a, mul_b, m_axis_tdata, m_axis_tvalid, err
  );
endinterface

// File: rtl/vedic_dot_sequencer.sv
// Feeds operand pairs into an external pipelined 8x8 multiplier and accumulates
// VEC_LEN products per vector, emitting one dot product per vector.
module vedic_dot_sequencer #(
  parameter int VEC_LEN     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int ACC_W       = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  vedic_dot_sequencer_if.master   bus
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] VEC_LEN_C = CNT_W'(VEC_LEN);

  typedef enum logic [1:0] {
    FEED  = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t             state_q;
  logic               tready_q;
  logic               tvalid_q;
  logic [ACC_W-1:0]   tdata_q;
  logic               err_q;
  logic [7:0]         mul_a_q;
  logic [7:0]         mul_b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [MUL_LATENCY:0] tok_q;
  logic [MUL_LATENCY:0] tok_d;

  logic beat;
  logic full;
  logic close;
  logic tap;
  logic others;
  logic out_hs;

  assign beat   = bus.s_axis_tvalid && tready_q;
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign full   = (cnt_d == VEC_LEN_C);
  assign close  = beat && (bus.s_axis_tlast || full);
  assign out_hs = tvalid_q && bus.m_axis_tready;

  // Token at the tap means mul_p currently holds the product of that beat.
  assign tap   = tok_q[MUL_LATENCY];
  assign acc_d = tap ? (acc_q + ACC_W'(bus.mul_p)) : acc_q;

  genvar gi;
  generate
    for (gi = 0; gi <= MUL_LATENCY; gi++) begin : g_tok
      if (gi == 0) begin : g_head
        assign tok_d[gi] = beat;
      end else begin : g_body
        assign tok_d[gi] = tok_q[gi-1];
      end
    end
    if (MUL_LATENCY > 0) begin : g_others
      assign others = |tok_q[MUL_LATENCY-1:0];
    end else begin : g_no_others
      assign others = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FEED;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      err_q    <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      tok_q    <= '0;
    end else begin
      tok_q <= tok_d;
      acc_q <= acc_d;
      err_q <= 1'b0;
      if (beat) begin
        mul_a_q <= bus.s_axis_tdata[7:0];
        mul_b_q <= bus.s_axis_tdata[15:8];
        cnt_q   <= cnt_d;
      end
      case (state_q)
        FEED: begin
          tready_q <= !close;
          if (close) begin
            state_q <= DRAIN;
            // Mismatch when tlast and the length limit do not land on the same beat.
            err_q   <= !(bus.s_axis_tlast && full);
          end
        end
        DRAIN: begin
          if (tap && !others) begin
            state_q  <= OUT;
            tvalid_q <= 1'b1;
            tdata_q  <= acc_d;
          end
        end
        OUT: begin
          if (out_hs) begin
            state_q  <= FEED;
            tvalid_q <= 1'b0;
            tready_q <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q  <= FEED;
          tready_q <= 1'b0;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.mul_a         = mul_a_q;
  assign bus.mul_b         = mul_b_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_vedic_dot_sequencer.sv
// Randomized and directed checks of vedic_dot_sequencer against a vector-level reference model.
module tb_vedic_dot_sequencer;
  localparam int VEC_LEN     = 4;
  localparam int MUL_LATENCY = 1;
  localparam int ACC_W       = 24;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;

  logic [7:0] va [8];
  logic [7:0] vb [8];
  bit         vl [8];

  vedic_dot_sequencer_if #(.ACC_W(ACC_W)) bus ();

  vedic_dot_sequencer #(
    .VEC_LEN(VEC_LEN), .MUL_LATENCY(MUL_LATENCY), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier core with one cycle of latency.
  always @(posedge clk) bus.mul_p <= 16'(bus.mul_a) * 16'(bus.mul_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one beat starting at a falling edge; returns the cycle index of its handshake edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input bit last, output int hs);
    int t;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = {b, a};
    bus.s_axis_tlast  = last;
    t = 0;
    while (!bus.s_axis_tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      check("beat_timeout", 32'd0, 32'd1);
      hs = -1;
    end else begin
      hs = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic run_vec(input string tag, input int n, input int gap_max, input int hold,
                         output logic [ACC_W-1:0] got, output int first_cyc);
    int k;
    int hs;
    int t;
    int errs;
    int g;
    bit exp_err;
    logic [ACC_W-1:0] exp_sum;
    // Reference: vector closes at the first tlast or at VEC_LEN beats.
    exp_sum = '0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      exp_sum = exp_sum + ACC_W'(int'(va[i]) * int'(vb[i]));
      k = i + 1;
      if (vl[i] || k == VEC_LEN) break;
    end
    exp_err = !(vl[k-1] && k == VEC_LEN);
    first_cyc = 0;
    hs = 0;
    for (int i = 0; i < k; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (hold > 0) bus.m_axis_tready = 1'b0;
      end
      if (hold > 0 && i == 0 && g == 0) begin
        @(negedge clk);
        bus.m_axis_tready = 1'b0;
      end
      send_beat(va[i], vb[i], vl[i], hs);
      if (i == 0) first_cyc = hs;
    end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    errs = 0;
    t = 0;
    while (!bus.m_axis_tvalid && t < 50) begin
      if (bus.err) errs++;
      @(negedge clk);
      t++;
    end
    got = bus.m_axis_tdata;
    if (t >= 50) begin
      check({tag, "_result_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(cyc - hs), 32'(MUL_LATENCY + 1));
      check({tag, "_sum"}, 32'(got), 32'(exp_sum));
      check({tag, "_err"}, 32'(errs), 32'(exp_err));
    end
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      check({tag, "_hold_tdata"}, 32'(bus.m_axis_tdata), 32'(got));
      check({tag, "_hold_stready"}, 32'(bus.s_axis_tready), 32'd0);
    end
    bus.m_axis_tready = 1'b1;
    $display("vector %s: beats=%0d sum=%06h expected=%06h err_expected=%0d", tag, k, got, exp_sum, exp_err);
  endtask

  task automatic load_nominal();
    va[0] = 8'hAB; vb[0] = 8'hBC; vl[0] = 0;
    va[1] = 8'hBC; vb[1] = 8'hCD; vl[1] = 0;
    va[2] = 8'hCD; vb[2] = 8'hDE; vl[2] = 0;
    va[3] = 8'hDE; vb[3] = 8'hEF; vl[3] = 1;
  endtask

  initial begin
    logic [ACC_W-1:0] got;
    int c1;
    int c2;
    int hs;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stready", 32'(bus.s_axis_tready), 32'd0);
    check("rst_mtvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_mtdata", 32'(bus.m_axis_tdata), 32'd0);
    check("rst_mul_ab", {16'd0, bus.mul_b, bus.mul_a}, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_stready", 32'(bus.s_axis_tready), 32'd1);

    load_nominal();
    run_vec("nominal1", 4, 0, 0, got, c1);
    check("nominal1_const", 32'(got), 32'h029528);
    run_vec("nominal2", 4, 0, 0, got, c2);
    check("b2b_period", 32'(c2 - c1), 32'(VEC_LEN + MUL_LATENCY + 2));

    for (int i = 0; i < 4; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; vl[i] = (i == 3); end
    run_vec("maxval", 4, 0, 0, got, c1);
    check("maxval_const", 32'(got), 32'h03F804);
    for (int i = 0; i < 4; i++) begin va[i] = 8'h00; vb[i] = 8'h00; vl[i] = (i == 3); end
    run_vec("zeros", 4, 0, 0, got, c1);
    check("zeros_const", 32'(got), 32'h0);

    load_nominal();
    run_vec("backpressure", 4, 0, 5, got, c1);
    for (int i = 0; i < 4; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 2); vl[i] = (i == 3); end
    run_vec("after_bp", 4, 0, 0, got, c1);

    load_nominal();
    vl[1] = 1;
    run_vec("early_tlast", 2, 0, 0, got, c1);
    check("early_const", 32'(got), 32'h011420);

    for (int i = 0; i < 4; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); vl[i] = 0; end
    run_vec("missing_tlast", 4, 0, 0, got, c1);
    load_nominal();
    run_vec("after_missing", 4, 0, 0, got, c1);

    load_nominal();
    run_vec("bubbles", 4, 3, 0, got, c1);
    check("bubbles_const", 32'(got), 32'h029528);

    // Reset in the middle of a vector.
    send_beat(8'h11, 8'h22, 1'b0, hs);
    send_beat(8'h33, 8'h44, 1'b0, hs);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mtvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("midrst_mtdata", 32'(bus.m_axis_tdata), 32'd0);
    check("midrst_mul_ab", {16'd0, bus.mul_b, bus.mul_a}, 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_stready", 32'(bus.s_axis_tready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_stready", 32'(bus.s_axis_tready), 32'd1);
    load_nominal();
    run_vec("after_rst", 4, 0, 0, got, c1);

    for (int v = 0; v < 25; v++) begin
      for (int i = 0; i < 4; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom);
        vl[i] = (i == 3) ? ($urandom_range(9, 0) < 7) : ($urandom_range(5, 0) == 0);
      end
      run_vec($sformatf("rand%0d", v), 4, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), got, c1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vedic_dot_sequencer.md
# vedic_dot_sequencer

Sequences an external pipelined 8x8 unsigned multiplier (the vedic8x8 core) to compute dot products for the matrix-multiply datapath. The block accepts operand pairs on an AXI-Stream slave, drives them into the multiplier one pair per cycle, and tracks in-flight products through the multiplier's fixed latency. It accumulates VEC_LEN products and emits one sum per vector on an AXI-Stream master. It sits between the operand fetch stream and the result collector and is the only driver of the multiplier's inputs.

## Interface
- VEC_LEN, 4: number of element pairs per dot product. Legal range 1..256.
- MUL_LATENCY, 1: cycles from mul_a/mul_b being held to the matching mul_p. Legal range 0..4; 0 means combinational.
- ACC_W, 24: accumulator and result width. Must be at least 16+clog2(VEC_LEN).
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  16  operand pair: [7:0] = a, [15:8] = b, both unsigned.
- s_axis_tvalid  in  1  operand pair valid.
- s_axis_tready  out  1  block accepts a pair this cycle.
- s_axis_tlast  in  1  marks the last pair of a vector.
- mul_a  out  8  multiplier operand a; registered.
- mul_b  out  8  multiplier operand b; registered.
- mul_p  in  16  multiplier product.
- m_axis_tdata  out  ACC_W  dot-product result.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accepts the result.
- err  out  1  one-cycle pulse on a tlast/length mismatch.

## Operation
- States:
  - FEED: s_axis_tready=1. A beat is accepted when s_axis_tvalid && s_axis_tready.
  - DRAIN: s_axis_tready=0. Waits for in-flight products to be accumulated.
  - OUT: s_axis_tready=0, m_axis_tvalid=1.
- On each accepted beat:
  - mul_a/mul_b load a/b at that edge.
  - A valid token enters a MUL_LATENCY+1 deep shift register.
  - The beat counter increments.
- When a token reaches the tap, the accumulator adds zero-extended mul_p. Arithmetic is unsigned modulo 2^ACC_W; no saturation.
- A vector closes on the first of two events:
  - a beat with s_axis_tlast=1, or
  - the VEC_LEN-th beat.
- On close, FEED -> DRAIN.
- err pulses in the cycle after close when the two events do not coincide:
  - Early tlast: beat count < VEC_LEN. The partial sum is still output.
  - Missing tlast: VEC_LEN-th beat without tlast. The vector closes anyway; the next beat starts a new vector.
- DRAIN -> OUT at the edge where the last in-flight product is added. m_axis_tdata is the final accumulator value.
- OUT -> FEED on m_axis_tvalid && m_axis_tready. At that edge the accumulator and beat counter clear.
- mul_a/mul_b hold their last values when no beat is accepted. Bubbles on s_axis_tvalid insert no tokens.

## Timing
- Reset values:
  - state FEED.
  - s_axis_tready=0 while rst=1, then 1 in the first cycle after rst deasserts.
  - mul_a=0, mul_b=0, m_axis_tdata=0, m_axis_tvalid=0, err=0.
  - Accumulator, beat counter and token pipe all 0.
- Throughput: one pair per cycle in FEED.
- Latency: m_axis_tvalid rises MUL_LATENCY+1 edges after the closing beat's handshake edge.
- Per-vector cost with continuous input and an always-ready sink: VEC_LEN + MUL_LATENCY + 2 cycles.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata holds stable and no input is accepted.
- rst mid-operation discards the partial sum, in-flight tokens and any pending output; no err pulse.
- VEC_LEN=1: every beat closes a vector. A tlast on that beat is correct; no tlast pulses err.

## Test plan
- Parameters for all scenarios: VEC_LEN=4, MUL_LATENCY=1, ACC_W=24.
- Nominal vector, back-to-back: pairs (0xAB,0xBC), (0xBC,0xCD), (0xCD,0xDE), (0xDE,0xEF) with tlast on beat 4 -> m_axis_tdata=0x029528 (169256). tvalid rises 2 edges after the beat-4 handshake; err stays 0.
- Max values: four pairs (0xFF,0xFF) -> 0x03F804 (260100), no overflow. Zeros vector -> 0x000000.
- Backpressure: hold m_axis_tready=0 for 5 cycles after tvalid -> tdata is stable, s_axis_tready=0 throughout. A second vector is accepted only after the handshake, and its result excludes the first vector's sum.
- Early tlast: (0xAB,0xBC), then (0xBC,0xCD) with tlast -> err pulses once; result 0x011420 (70688).
- Missing tlast: 4 beats without tlast -> err pulses; the result equals the 4-product sum. The next beat starts a new vector.
- Bubbles and reset:
  - Insert tvalid=0 gaps between beats of the nominal vector -> same result 0x029528.
  - Assert rst after beat 2 -> all outputs return to reset values. A following full vector yields its own sum only.
